spinner_input_conditioner: RTL and testbench
============================================

Name: spinner_input_conditioner

Overview:
- Upstream stage of the 7-segment spinner/fade block. Takes raw switch pins and produces clean control values for it.
- Raw pins are speed[2:0], tail and direction. Each is synchronised and debounced, and the block emits a single-cycle change strobe.
- The block also generates the spinner step tick, with period set by the debounced speed. The downstream block then advances state on this tick instead of on its own compare counter.

Parameters:
- SYNC_STAGES, 2: synchroniser flops per raw input (min 2).
- SAMPLE_DIV_WIDTH, 10: debounce sample tick fires every 2^SAMPLE_DIV_WIDTH clocks.
- DEBOUNCE_COUNT, 4: consecutive agreeing samples required to accept a new value (min 2).
- STEP_SHIFT, 18: step period = (speed+1) << STEP_SHIFT clocks.
- STEP_WIDTH, 22: step counter width; must hold (8 << STEP_SHIFT) - 1.

Ports:
- clk, input, 1: sole clock; all flops on posedge.
- reset, input, 1: asynchronous, active-low (asserted at 0); clears all state immediately, release is synchronous to clk.
- sw_speed_raw, input, 3: raw speed switches, asynchronous to clk.
- sw_tail_raw, input, 1: raw tail-enable switch.
- sw_dir_raw, input, 1: raw direction switch.
- step_en, input, 1: enables step tick generation.
- speed, output, 3: debounced speed, 0 = fastest.
- tail, output, 1: debounced tail enable.
- direction, output, 1: debounced direction, 1 = forward.
- changed, output, 1: one-cycle pulse when any debounced output updates.
- step_tick, output, 1: one-cycle pulse per spinner step.

Behaviour:
- Reset values (immediate on reset=0): speed=0, tail=1, direction=0, changed=0, step_tick=0. Synchronisers take the same values as the outputs they feed. Sample divider, debounce counters and step counter are 0.
- Synchroniser: SYNC_STAGES flop chain per raw bit. Only the last stage is used downstream.
- Sample divider: free-running SAMPLE_DIV_WIDTH counter.
  - sample_tick=1 for one cycle when the counter is all-ones; counter then wraps to 0.
  - First tick after reset release occurs on cycle 2^SAMPLE_DIV_WIDTH - 1.
- Debounce, tail and direction, independent channels:
  - On sample_tick, if synced bit != stable output, increment that channel's counter; else clear it.
  - When the counter would reach DEBOUNCE_COUNT, update the output next cycle and clear the counter.
  - Glitch shorter than DEBOUNCE_COUNT samples: output unchanged.
- Debounce, speed (3-bit group):
  - Keep a last-sample register, updated every sample_tick.
  - On sample_tick, increment the group counter only if synced != speed AND synced == last-sample; otherwise set the counter to 1 if synced != speed, else 0.
  - Accept on reaching DEBOUNCE_COUNT. Intermediate codes during multi-bit switching must never appear on speed.
- Latency from a raw change to an output change: SYNC_STAGES + 1 clocks, plus the wait to the next sample tick, plus (DEBOUNCE_COUNT-1) sample periods.
- changed: asserted the cycle after any output register updates. Simultaneous updates of several channels give one pulse.
- Step generator:
  - terminal = ((speed+1) << STEP_SHIFT) - 1, computed in STEP_WIDTH bits.
  - If step_en=0: counter held at 0, step_tick=0.
  - Else if counter >= terminal: step_tick=1 for that cycle (registered output, visible next cycle), counter=0.
  - Else counter+1.
  - Speed decreasing mid-period: the >= compare fires on the next cycle; no wrap through the full counter range.
  - step_en deasserted mid-period: counter restarts from 0 on re-enable.
- Reset mid-operation: all outputs return to reset values within the same cycle (asynchronous). Pending debounce progress is discarded.
- No combinational path from any input to any output.

Test Plan (SAMPLE_DIV_WIDTH=2, DEBOUNCE_COUNT=4, STEP_SHIFT=2, SYNC_STAGES=2):
- Reset: drive reset=0 mid-run with tail=0, speed=5 -> speed=0, tail=1, direction=0, changed=0, step_tick=0 in the same cycle, before any clk edge.
- Clean change: sw_dir_raw 0->1 held -> direction rises after 4 sample ticks (~15-19 clocks), changed pulses exactly once for 1 cycle.
- Glitch: sw_tail_raw low for 2 sample periods (8 clocks), then high -> tail stays 1, changed never pulses.
- Speed group skew: sw_speed_raw 000->011 with bit1 changing 1 sample tick after bit0 -> speed goes directly 0->3 and never shows 1; single changed pulse.
- Step period: speed=2, step_en=1 held -> step_tick pulses every 12 clocks, each pulse exactly 1 cycle wide. Then speed 7->0 mid-period at count 20 -> tick on the next cycle, then every 4 clocks.
- step_en gating: step_en=0 for 50 clocks -> no step_tick. Re-enable with speed=0 -> first tick 4 clocks later.

Source files
------------

// File: rtl/spinner_input_conditioner.sv
// spinner_input_conditioner
// Conditions the raw spinner switches: synchronises and debounces speed,
// tail and direction, flags any accepted change with a one-cycle strobe, and
// produces the spinner step tick whose period follows the debounced speed.
module spinner_input_conditioner #(
  parameter int SYNC_STAGES      = 2,
  parameter int SAMPLE_DIV_WIDTH = 10,
  parameter int DEBOUNCE_COUNT   = 4,
  parameter int STEP_SHIFT       = 18,
  parameter int STEP_WIDTH       = 22
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] sw_speed_raw,
  input  logic       sw_tail_raw,
  input  logic       sw_dir_raw,
  input  logic       step_en,
  output logic [2:0] speed,
  output logic       tail,
  output logic       direction,
  output logic       changed,
  output logic       step_tick
);

  localparam int              DB_W    = $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_COUNT - 1);

  // Step terminal count: ((speed + 1) << STEP_SHIFT) - 1, kept in STEP_WIDTH bits.
  function automatic logic [STEP_WIDTH-1:0] step_terminal(input logic [2:0] spd);
    logic [STEP_WIDTH-1:0] base;
    base = STEP_WIDTH'(spd) + STEP_WIDTH'(1);
    return (base << STEP_SHIFT) - STEP_WIDTH'(1);
  endfunction

  logic [SYNC_STAGES-1:0][2:0]  speed_sync;
  logic [SYNC_STAGES-1:0]       tail_sync;
  logic [SYNC_STAGES-1:0]       dir_sync;
  logic [2:0]                   speed_s;
  logic                         tail_s;
  logic                         dir_s;

  logic [SAMPLE_DIV_WIDTH-1:0]  sample_div;
  logic                         sample_tick;

  logic [DB_W-1:0]              tail_cnt;
  logic [DB_W-1:0]              dir_cnt;
  logic [DB_W-1:0]              speed_cnt;
  logic [2:0]                   speed_last;

  logic                         tail_accept;
  logic                         dir_accept;
  logic                         speed_accept;

  logic [STEP_WIDTH-1:0]        step_cnt;
  logic [STEP_WIDTH-1:0]        step_term;

  // Only the final synchroniser stage is safe to use downstream.
  assign speed_s = speed_sync[SYNC_STAGES-1];
  assign tail_s  = tail_sync[SYNC_STAGES-1];
  assign dir_s   = dir_sync[SYNC_STAGES-1];

  assign sample_tick = &sample_div;

  // A channel accepts when this sample would be the DEBOUNCE_COUNT-th agreeing one.
  assign tail_accept  = sample_tick && (tail_s != tail)     && (tail_cnt == DB_LAST);
  assign dir_accept   = sample_tick && (dir_s != direction) && (dir_cnt == DB_LAST);
  assign speed_accept = sample_tick && (speed_s != speed) && (speed_s == speed_last)
                        && (speed_cnt == DB_LAST);

  assign step_term = step_terminal(speed);

  // Synchroniser chains; reset values match the outputs they feed so no
  // spurious debounce activity follows reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      speed_sync <= '0;
      tail_sync  <= '1;
      dir_sync   <= '0;
    end else begin
      speed_sync <= {speed_sync[SYNC_STAGES-2:0], sw_speed_raw};
      tail_sync  <= {tail_sync[SYNC_STAGES-2:0], sw_tail_raw};
      dir_sync   <= {dir_sync[SYNC_STAGES-2:0], sw_dir_raw};
    end
  end

  // Free-running sample divider; wraps naturally after the all-ones tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sample_div <= '0;
    else        sample_div <= sample_div + 1'b1;
  end

  // Tail debounce: count consecutive disagreeing samples, accept on the last one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tail     <= 1'b1;
      tail_cnt <= '0;
    end else if (sample_tick) begin
      if (tail_accept) begin
        tail     <= tail_s;
        tail_cnt <= '0;
      end else if (tail_s != tail) begin
        tail_cnt <= tail_cnt + 1'b1;
      end else begin
        tail_cnt <= '0;
      end
    end
  end

  // Direction debounce: same scheme as tail.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      direction <= 1'b0;
      dir_cnt   <= '0;
    end else if (sample_tick) begin
      if (dir_accept) begin
        direction <= dir_s;
        dir_cnt   <= '0;
      end else if (dir_s != direction) begin
        dir_cnt <= dir_cnt + 1'b1;
      end else begin
        dir_cnt <= '0;
      end
    end
  end

  // Speed debounce as a group: the run only grows while the whole code is
  // repeated, so codes seen mid-transition restart the count instead of
  // being accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      speed      <= '0;
      speed_cnt  <= '0;
      speed_last <= '0;
    end else if (sample_tick) begin
      speed_last <= speed_s;
      if (speed_accept) begin
        speed     <= speed_s;
        speed_cnt <= '0;
      end else if (speed_s != speed) begin
        if (speed_s == speed_last) speed_cnt <= speed_cnt + 1'b1;
        else                       speed_cnt <= DB_W'(1);
      end else begin
        speed_cnt <= '0;
      end
    end
  end

  // One change strobe, aligned with the first cycle the new value is visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) changed <= 1'b0;
    else        changed <= tail_accept | dir_accept | speed_accept;
  end

  // Step generator; the >= compare lets a shortened period fire at once
  // instead of wrapping the counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_cnt  <= '0;
      step_tick <= 1'b0;
    end else if (!step_en) begin
      step_cnt  <= '0;
      step_tick <= 1'b0;
    end else if (step_cnt >= step_term) begin
      step_cnt  <= '0;
      step_tick <= 1'b1;
    end else begin
      step_cnt  <= step_cnt + 1'b1;
      step_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spinner_input_conditioner.sv
// Bench for spinner_input_conditioner: directed sequences, a table of step
// periods, and a randomized run against a sample-history reference model.
module tb_spinner_input_conditioner;

  localparam int SYNC_STAGES      = 2;
  localparam int SAMPLE_DIV_WIDTH = 2;
  localparam int DEBOUNCE_COUNT   = 4;
  localparam int STEP_SHIFT       = 2;
  localparam int STEP_WIDTH       = 6;
  localparam int SAMPLE_PERIOD    = 1 << SAMPLE_DIV_WIDTH;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] sw_speed_raw = 3'd0;
  logic       sw_tail_raw = 1'b1;
  logic       sw_dir_raw = 1'b0;
  logic       step_en = 1'b0;
  logic [2:0] speed;
  logic       tail;
  logic       direction;
  logic       changed;
  logic       step_tick;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] spd;
    int         period;
  } step_vec_t;

  always #5 clk = ~clk;

  spinner_input_conditioner #(
    .SYNC_STAGES     (SYNC_STAGES),
    .SAMPLE_DIV_WIDTH(SAMPLE_DIV_WIDTH),
    .DEBOUNCE_COUNT  (DEBOUNCE_COUNT),
    .STEP_SHIFT      (STEP_SHIFT),
    .STEP_WIDTH      (STEP_WIDTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sw_speed_raw(sw_speed_raw),
    .sw_tail_raw (sw_tail_raw),
    .sw_dir_raw  (sw_dir_raw),
    .step_en     (step_en),
    .speed       (speed),
    .tail        (tail),
    .direction   (direction),
    .changed     (changed),
    .step_tick   (step_tick)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d expected range %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    cyc(3);
    reset = 1'b1;
  endtask

  // Waits for the next observed step_tick; n = negedges waited, 0 on timeout.
  task automatic wait_tick(output int n);
    n = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (step_tick) begin
        n = i;
        break;
      end
    end
  endtask

  // ---------------- reference model ----------------
  logic [4:0] rawq[$];
  int         tail_hist[$];
  int         dir_hist[$];
  int         spd_hist[$];
  int         m_speed, m_tail, m_dir, m_changed, m_tick, m_elapsed, m_n;

  task automatic model_init();
    rawq.delete(); tail_hist.delete(); dir_hist.delete(); spd_hist.delete();
    m_speed = 0; m_tail = 1; m_dir = 0; m_changed = 0; m_tick = 0;
    m_elapsed = 0; m_n = 0;
  endtask

  // True when the last DEBOUNCE_COUNT samples all differ from cur.
  function automatic bit all_differ(input int h[$], input int cur);
    if (h.size() < DEBOUNCE_COUNT) return 0;
    for (int i = h.size() - DEBOUNCE_COUNT; i < h.size(); i++)
      if (h[i] == cur) return 0;
    return 1;
  endfunction

  // True when the last DEBOUNCE_COUNT samples are one identical code.
  function automatic bit all_same(input int h[$]);
    if (h.size() < DEBOUNCE_COUNT) return 0;
    for (int i = h.size() - DEBOUNCE_COUNT; i < h.size(); i++)
      if (h[i] != h[h.size() - 1]) return 0;
    return 1;
  endfunction

  // Called once per rising edge with the inputs present at that edge.
  task automatic model_edge();
    logic [4:0] syn;
    int         upd;
    int         s;
    rawq.push_back({sw_speed_raw, sw_tail_raw, sw_dir_raw});
    if (rawq.size() > SYNC_STAGES + 1) void'(rawq.pop_front());
    syn = (rawq.size() == SYNC_STAGES + 1) ? rawq[0] : 5'b000_1_0;
    // step period taken from the speed in force before this edge
    if (!step_en) begin
      m_elapsed = 0; m_tick = 0;
    end else if (m_elapsed + 1 >= (m_speed + 1) * (1 << STEP_SHIFT)) begin
      m_elapsed = 0; m_tick = 1;
    end else begin
      m_elapsed++; m_tick = 0;
    end
    upd = 0;
    if (m_n % SAMPLE_PERIOD == SAMPLE_PERIOD - 1) begin
      tail_hist.push_back(int'(syn[1]));
      dir_hist.push_back(int'(syn[0]));
      spd_hist.push_back(int'(syn[4:2]));
      if (all_differ(tail_hist, m_tail)) begin m_tail = tail_hist[$]; upd = 1; end
      if (all_differ(dir_hist, m_dir))   begin m_dir = dir_hist[$];   upd = 1; end
      s = spd_hist[$];
      if (all_same(spd_hist) && s != m_speed) begin m_speed = s; upd = 1; end
    end
    m_changed = upd;
    m_n++;
  endtask

  // ---------------- main test ----------------
  initial begin
    step_vec_t tbl[4];
    int lat, nchg, nbad, n, hold, r;

    tbl[0] = '{spd: 3'd0, period: 4};
    tbl[1] = '{spd: 3'd2, period: 12};
    tbl[2] = '{spd: 3'd5, period: 24};
    tbl[3] = '{spd: 3'd7, period: 32};

    // reset values before any clock edge
    #1 reset = 1'b0;
    #1;
    check("rst_speed", speed, 3'd0);
    check("rst_tail", tail, 1'b1);
    check("rst_dir", direction, 1'b0);
    check("rst_changed", changed, 1'b0);
    check("rst_step_tick", step_tick, 1'b0);
    cyc(2);
    reset = 1'b1;
    cyc(10);

    // clean direction change
    sw_dir_raw = 1'b1;
    lat = 0; nchg = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (direction && lat == 0) lat = i;
      if (changed) nchg++;
    end
    check_range("dir_latency", lat, 15, 19);
    check("dir_changed_pulses", nchg, 1);

    // tail glitch of two sample periods
    sw_tail_raw = 1'b0;
    nbad = 0; nchg = 0;
    for (int i = 1; i <= 48; i++) begin
      @(negedge clk);
      if (i == 8) sw_tail_raw = 1'b1;
      if (!tail) nbad++;
      if (changed) nchg++;
    end
    check("glitch_tail_low_cycles", nbad, 0);
    check("glitch_changed_pulses", nchg, 0);

    // speed group with bit1 lagging bit0 by one sample period
    sw_speed_raw = 3'b001;
    nbad = 0; nchg = 0;
    for (int i = 1; i <= 44; i++) begin
      @(negedge clk);
      if (i == 4) sw_speed_raw = 3'b011;
      if (speed == 3'd1) nbad++;
      if (changed) nchg++;
    end
    check("skew_speed_final", speed, 3'd3);
    check("skew_speed_one_seen", nbad, 0);
    check("skew_changed_pulses", nchg, 1);

    // table of step periods
    foreach (tbl[k]) begin
      step_en = 1'b0;
      sw_speed_raw = tbl[k].spd;
      cyc(30);
      check("tbl_speed", speed, tbl[k].spd);
      step_en = 1'b1;
      wait_tick(n);
      check("tbl_first_tick_seen", (n != 0), 1'b1);
      wait_tick(n);
      check("tbl_period", n, tbl[k].period);
      @(negedge clk);
      check("tbl_tick_width", step_tick, 1'b0);
    end

    // speed 7 -> 0 mid-period
    step_en = 1'b0;
    sw_speed_raw = 3'd7;
    cyc(30);
    check("drop_speed7", speed, 3'd7);
    step_en = 1'b1;
    wait_tick(n);
    sw_speed_raw = 3'd0;
    nbad = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (speed == 3'd0) break;
      if (step_tick) nbad++;
    end
    check("drop_speed0", speed, 3'd0);
    check("drop_no_early_tick", nbad, 0);
    @(negedge clk);
    check("drop_tick_next_cycle", step_tick, 1'b1);
    wait_tick(n);
    check("drop_period_a", n, 4);
    wait_tick(n);
    check("drop_period_b", n, 4);

    // step_en gating and restart
    step_en = 1'b0;
    nbad = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (step_tick) nbad++;
    end
    check("gate_no_ticks", nbad, 0);
    step_en = 1'b1;
    wait_tick(n);
    check("gate_first_tick", n, 4);

    // asynchronous reset mid-operation
    sw_tail_raw = 1'b0;
    sw_speed_raw = 3'd5;
    sw_dir_raw = 1'b1;
    cyc(30);
    check("arst_pre_tail", tail, 1'b0);
    check("arst_pre_speed", speed, 3'd5);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_speed", speed, 3'd0);
    check("arst_tail", tail, 1'b1);
    check("arst_dir", direction, 1'b0);
    check("arst_changed", changed, 1'b0);
    check("arst_step_tick", step_tick, 1'b0);
    sw_tail_raw = 1'b1;
    sw_speed_raw = 3'd0;
    sw_dir_raw = 1'b0;
    step_en = 1'b1;
    cyc(2);

    // randomized run against the model
    model_init();
    reset = 1'b1;
    hold = 1;
    for (int c = 0; c < 2500; c++) begin
      hold--;
      if (hold <= 0) begin
        r = $urandom_range(0, 9);
        case (r)
          0, 1, 2: sw_speed_raw = 3'($urandom_range(0, 7));
          3, 4:    sw_tail_raw = ~sw_tail_raw;
          5, 6:    sw_dir_raw = ~sw_dir_raw;
          7:       step_en = ~step_en;
          8:       begin sw_tail_raw = ~sw_tail_raw; sw_dir_raw = ~sw_dir_raw; end
          default: ;
        endcase
        hold = (r == 8) ? $urandom_range(1, 6) : $urandom_range(1, 28);
      end
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("rand_outputs", {speed, tail, direction, changed, step_tick},
            {3'(m_speed), 1'(m_tail), 1'(m_dir), 1'(m_changed), 1'(m_tick)});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule
